xdisp_scan: RTL and testbench
=============================

XDISP_SCAN -- requirements
Module: xdisp_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 8..2^20.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port sel  input  1  bus select from the address decoder.
REQ-005 SHALL have port we  input  1  write enable, qualified by sel.
REQ-006 SHALL have port addr  input  3  register address.
REQ-007 SHALL have port data_in  input  8  write data.
REQ-008 SHALL have port data_out  output  8  read data, combinational from addr, independent of sel.
REQ-009 SHALL have port disp_ctrl  output  12  registered; [11:8] anodes for digits 3..0, active-low; [7] dp, active-low; [6:0] segments gfedcba, active-low.

Function
REQ-010 SHALL implement register map: 0-3 shadow digit regs (bit7 dp, bit4 blank, bits3:0 hex value, bits6:5 read 0); 4 control (bit0 enable, bits3:1 bright); 5 commit (write) / status (read {5'b0, pending, idx[1:0]}); 6-7 writes ignored, read 0x00.
REQ-011 SHALL update a register on a clock edge with sel=1 and we=1; the new value SHALL be readable the next cycle.
REQ-012 SHALL hold a 4-entry active digit buffer that drives the display; shadow writes SHALL NOT affect the display until committed.
REQ-013 SHALL set pending=1 on any write to addr 5.
REQ-014 SHALL copy all four shadow regs to active and clear pending on the edge where pending=1 and either (enable=1, idx=3, cnt=SCAN_DIV-1) or enable=0.
REQ-015 SHALL, when a commit edge coincides with a shadow write, copy the pre-write shadow value; the new value waits for the next commit.
REQ-016 SHALL, when a commit edge coincides with a new addr-5 write, leave pending=1.
REQ-017 SHALL, while enable=1, increment cnt (0..SCAN_DIV-1) every cycle; at SCAN_DIV-1, cnt SHALL wrap to 0 and idx SHALL advance modulo 4 (3->0).
REQ-018 SHALL, while enable=0, force cnt=0 and idx=0 on every edge and register disp_ctrl=12'hFFF.
REQ-019 SHALL compute on_len = ((bright+1)*SCAN_DIV)>>3 as an integer, with on_len >= 1.
REQ-020 SHALL register an anode[idx] of 0 (others 1) only when enable=1, 1 <= cnt <= on_len, and the active blank bit of digit idx is 0; cnt=0 is a mandatory dead cycle with all anodes off.
REQ-021 SHALL register segments as the standard hex decode of the active digit idx (0:0xC0, 1:0xF9, 5:0x92, 8:0x80, F:0x8E, others standard), with bit7 = ~dp; segments SHALL be 0xFF whenever all anodes are off.
REQ-022 SHALL have one-cycle latency: disp_ctrl at cycle n+1 reflects cnt, idx, active buffer and control at cycle n.
REQ-023 SHALL apply a bright change on the next cycle without restarting cnt.

Reset
REQ-024 SHALL, on rst=1 at an edge, set shadow and active regs to 0x10 (blank), control to 0x0E (enable=0, bright=7), pending=0, cnt=0, idx=0, disp_ctrl=12'hFFF; rst SHALL override any same-cycle bus write.

Verification (SCAN_DIV=8)
REQ-025 SHALL cover reset: assert rst mid-scan -> next cycle disp_ctrl=0xFFF; reads return addr0=0x10, addr4=0x0E, addr5=0x00.
REQ-026 SHALL cover basic display: write addr0=0x05, addr5, addr4=0x0F -> digit-0 slots show disp_ctrl=0xE92 for cnt 1..7 and 0xFFF for cnt 0; other digits stay 0xFFF (blank).
REQ-027 SHALL cover brightness: bright=0 (addr4=0x01) -> anode low only at cnt=1 (1 of 8 cycles); bright=3 -> cnt 1..4.
REQ-028 SHALL cover deferred commit: with enable=1, write addr1=0x08 and commit at idx=1 -> status pending=1 until the idx=3/cnt=7 edge; digit 1 shows 0xD80 from the next frame; write at commit edge not shown.
REQ-029 SHALL cover disable mid-frame: addr4=0x0E at idx=2, cnt=4 -> next edge cnt=idx=0, disp_ctrl=0xFFF; a pending commit completes on that edge (status reads 0x00).
REQ-030 SHALL cover dp and blank: digit3=0x8F -> 0x70E during its slot; digit3=0x1F -> anode 3 never low, 0xFFF throughout the slot.

Source files
------------

// File: rtl/xdisp_scan.sv
// Four-digit multiplexed 7-segment scanner with shadow/active digit buffers,
// frame-synchronous commit and PWM brightness; disp_ctrl is registered (1-cycle latency).
module xdisp_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [11:0] disp_ctrl
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  // Active entries keep only what the display uses: {dp, blank, hex}
  logic [7:0]    shadow_q [4];
  logic [7:0]    shadow_d [4];
  logic [5:0]    active_q [4];
  logic [5:0]    active_d [4];
  logic [3:0]    ctrl_q, ctrl_d;
  logic          pending_q, pending_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   disp_q, disp_d;

  logic          wr, enable, commit, lit;
  logic [2:0]    bright;
  logic [23:0]   on_prod, on_len, cnt_ext;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign wr     = sel & we;
  assign enable = ctrl_q[0];
  assign bright = ctrl_q[3:1];
  assign commit = pending_q & (~enable | ((idx_q == 2'd3) && (cnt_q == CNT_MAX)));

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    disp_d    = 12'hFFF;
    on_prod   = 24'({1'b0, bright} + 4'd1) * 24'(SCAN_DIV);
    on_len    = on_prod >> 3;
    cnt_ext   = 24'(cnt_q);
    lit       = 1'b0;

    // Commit reads the pre-write shadow; a same-edge commit write re-arms pending
    if (commit) begin
      for (int i = 0; i < 4; i++)
        active_d[i] = {shadow_q[i][7], shadow_q[i][4], shadow_q[i][3:0]};
      pending_d = 1'b0;
    end

    if (wr) begin
      case (addr)
        3'd0, 3'd1, 3'd2, 3'd3: shadow_d[addr[1:0]] = data_in & 8'h9F;
        3'd4:                   ctrl_d    = data_in[3:0];
        3'd5:                   pending_d = 1'b1;
        default: ;
      endcase
    end

    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      idx_d = 2'd0;
    end

    if (on_len == 24'd0)
      on_len = 24'd1;
    // cnt==0 is a dead cycle between digits to avoid ghosting
    lit = enable && (cnt_ext >= 24'd1) && (cnt_ext <= on_len) && !active_q[idx_q][4];
    if (lit)
      disp_d = {~(4'b0001 << idx_q), ~active_q[idx_q][5], hex7(active_q[idx_q][3:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '{default: 8'h10};
      active_q  <= '{default: 6'h10};
      ctrl_q    <= 4'hE;
      pending_q <= 1'b0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      disp_q    <= 12'hFFF;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: data_out = shadow_q[addr[1:0]];
      3'd4:                   data_out = {4'h0, ctrl_q};
      3'd5:                   data_out = {5'b0, pending_q, idx_q};
      default:                data_out = 8'h00;
    endcase
  end

  assign disp_ctrl = disp_q;

endmodule

// File: tb/tb_xdisp_scan.sv
// Directed bench for xdisp_scan at SCAN_DIV=8: register-map vector table plus
// frame-level display sequences (brightness, deferred commit, disable, dp/blank, reset).
module tb_xdisp_scan;

  logic        clk, rst, sel, we;
  logic [2:0]  addr;
  logic [7:0]  data_in, data_out;
  logic [11:0] disp_ctrl;
  int          checks = 0;
  int          passes = 0;

  xdisp_scan #(.SCAN_DIV(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .disp_ctrl(disp_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    addr = a;
    #1;
    chk(nm, {4'h0, data_out}, {4'h0, exp});
  endtask

  // One clock with an optional bus write, then check disp_ctrl after the edge
  task automatic cyc(input logic w, input logic [2:0] a, input logic [7:0] d,
                     input logic [11:0] exp, input string nm);
    sel = w; we = w; addr = a; data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; data_in = 8'h00;
    chk(nm, disp_ctrl, exp);
  endtask

  // Expected output for frame position j (idx = j/8, cnt = j%8); e* = lit pattern per digit
  function automatic logic [11:0] expv(input int j, input logic [11:0] e0, input logic [11:0] e1,
                                       input logic [11:0] e2, input logic [11:0] e3, input int onl);
    int c;
    c = j % 8;
    if (c < 1 || c > onl) return 12'hFFF;
    case ((j / 8) % 4)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return e3;
    endcase
  endfunction

  task automatic frame(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2,
                       input logic [11:0] e3, input int onl, input string nm);
    for (int j = 0; j < 32; j++)
      cyc(j == 0 ? w : 1'b0, a, d, expv(j, e0, e1, e2, e3, onl), $sformatf("%s_j%0d", nm, j));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; data_in = 8'h00;

    vecs[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h10, "rd_a0_reset"};
    vecs[1]  = '{1'b0, 1'b0, 3'd4, 8'h00, 8'h0E, "rd_a4_reset"};
    vecs[2]  = '{1'b0, 1'b0, 3'd5, 8'h00, 8'h00, "rd_a5_reset"};
    vecs[3]  = '{1'b1, 1'b1, 3'd2, 8'hFF, 8'h9F, "wr_a2_mask"};
    vecs[4]  = '{1'b1, 1'b1, 3'd6, 8'h55, 8'h00, "wr_a6_ignored"};
    vecs[5]  = '{1'b1, 1'b1, 3'd7, 8'hAA, 8'h00, "wr_a7_ignored"};
    vecs[6]  = '{1'b1, 1'b1, 3'd4, 8'h2C, 8'h0C, "wr_a4_ctrl"};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 8'h00, 8'h04, "wr_a5_pending"};
    vecs[8]  = '{1'b0, 1'b0, 3'd5, 8'h00, 8'h00, "commit_disabled"};
    vecs[9]  = '{1'b1, 1'b1, 3'd3, 8'h80, 8'h80, "wr_a3_dp"};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 8'h77, 8'h10, "we_without_sel"};
    vecs[11] = '{1'b1, 1'b0, 3'd1, 8'h33, 8'h10, "sel_without_we"};

    do_reset();
    chk("reset_disp", disp_ctrl, 12'hFFF);

    for (int i = 0; i < 12; i++) begin
      sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr; data_in = vecs[i].wd;
      @(posedge clk); #1;
      sel = 1'b0; we = 1'b0; data_in = 8'h00;
      chk(vecs[i].name, {4'h0, data_out}, {4'h0, vecs[i].exp});
    end

    // Basic display: digit 0 = 5, commit while disabled, then enable at bright 7
    do_reset();
    cyc(1'b1, 3'd0, 8'h05, 12'hFFF, "setup_d0");
    cyc(1'b1, 3'd5, 8'h00, 12'hFFF, "setup_commit");
    cyc(1'b1, 3'd4, 8'h0F, 12'hFFF, "setup_enable");
    frame(1'b0, 3'd0, 8'h00, 12'hE92, 12'hFFF, 12'hFFF, 12'hFFF, 7, "basic");
    frame(1'b1, 3'd4, 8'h01, 12'hE92, 12'hFFF, 12'hFFF, 12'hFFF, 1, "br0");
    frame(1'b1, 3'd4, 8'h07, 12'hE92, 12'hFFF, 12'hFFF, 12'hFFF, 4, "br3");

    // Deferred commit: digit1=8 committed at idx 1, applied at the idx3/cnt7 edge
    for (int j = 0; j < 32; j++) begin
      logic [11:0] e;
      e = expv(j, 12'hE92, 12'hFFF, 12'hFFF, 12'hFFF, 4);
      case (j)
        8:  cyc(1'b1, 3'd1, 8'h08, e, $sformatf("defer_j%0d", j));
        9:  begin
              cyc(1'b1, 3'd5, 8'h00, e, $sformatf("defer_j%0d", j));
              rd(3'd5, 8'h05, "status_pend_idx1");
            end
        20: begin
              cyc(1'b0, 3'd0, 8'h00, e, $sformatf("defer_j%0d", j));
              rd(3'd5, 8'h06, "status_pend_idx2");
            end
        31: begin
              cyc(1'b1, 3'd1, 8'h03, e, $sformatf("defer_j%0d", j));
              rd(3'd5, 8'h00, "status_committed");
              rd(3'd1, 8'h03, "rd_a1_late");
            end
        default: cyc(1'b0, 3'd0, 8'h00, e, $sformatf("defer_j%0d", j));
      endcase
    end

    // Digit1 shows 8 (late write not shown); commit write on the commit edge keeps pending
    for (int j = 0; j < 32; j++) begin
      logic [11:0] e;
      e = expv(j, 12'hE92, 12'hD80, 12'hFFF, 12'hFFF, 4);
      if (j == 5 || j == 31) cyc(1'b1, 3'd5, 8'h00, e, $sformatf("shown8_j%0d", j));
      else                   cyc(1'b0, 3'd0, 8'h00, e, $sformatf("shown8_j%0d", j));
    end
    rd(3'd5, 8'h04, "pending_rearmed");

    // Digit1 now 3; disable at idx2/cnt4 with a commit still pending
    for (int j = 0; j <= 20; j++) begin
      logic [11:0] e;
      e = expv(j, 12'hE92, 12'hDB0, 12'hFFF, 12'hFFF, 4);
      if (j == 2)       cyc(1'b1, 3'd3, 8'h8F, e, $sformatf("dis_j%0d", j));
      else if (j == 20) cyc(1'b1, 3'd4, 8'h0E, e, $sformatf("dis_j%0d", j));
      else              cyc(1'b0, 3'd0, 8'h00, e, $sformatf("dis_j%0d", j));
    end
    rd(3'd5, 8'h06, "status_before_disable");
    cyc(1'b0, 3'd0, 8'h00, 12'hFFF, "disabled_disp");
    rd(3'd5, 8'h00, "status_disabled_commit");
    rd(3'd3, 8'h8F, "rd_a3_dp");

    // Digit3 = F with dp lit
    cyc(1'b1, 3'd4, 8'h0F, 12'hFFF, "reenable");
    frame(1'b0, 3'd0, 8'h00, 12'hE92, 12'hDB0, 12'hFFF, 12'h70E, 7, "dp");

    // Digit3 blanked
    cyc(1'b1, 3'd4, 8'h0E, 12'hFFF, "blank_disable");
    cyc(1'b1, 3'd3, 8'h1F, 12'hFFF, "blank_wr_a3");
    cyc(1'b1, 3'd5, 8'h00, 12'hFFF, "blank_commit");
    cyc(1'b0, 3'd0, 8'h00, 12'hFFF, "blank_commit_edge");
    rd(3'd3, 8'h1F, "rd_a3_blank");
    rd(3'd5, 8'h00, "status_blank_done");
    cyc(1'b1, 3'd4, 8'h0F, 12'hFFF, "blank_enable");
    frame(1'b0, 3'd0, 8'h00, 12'hE92, 12'hDB0, 12'hFFF, 12'hFFF, 7, "blank");

    // Reset mid-scan, overriding a same-cycle write
    cyc(1'b0, 3'd0, 8'h00, 12'hFFF, "prerst_j0");
    cyc(1'b0, 3'd0, 8'h00, 12'hE92, "prerst_j1");
    cyc(1'b0, 3'd0, 8'h00, 12'hE92, "prerst_j2");
    rst = 1'b1;
    cyc(1'b1, 3'd0, 8'h33, 12'hFFF, "rst_disp");
    rst = 1'b0;
    rd(3'd0, 8'h10, "rst_rd_a0");
    rd(3'd4, 8'h0E, "rst_rd_a4");
    rd(3'd5, 8'h00, "rst_rd_a5");
    cyc(1'b0, 3'd0, 8'h00, 12'hFFF, "post_rst_disp");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
